// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: state encoding shared by the APB command master.
package apb_cmd_master_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;
endpackage

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: one-command-at-a-time APB3 master with a wait-state timeout.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16,
  parameter int TWIDTH  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [AWIDTH-1:0] REQ_ADDR,
  input  logic [DWIDTH-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DWIDTH-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam logic [TWIDTH-1:0] TO_LIMIT = TWIDTH'(TIMEOUT);
  state_t              r_state;
  logic [TWIDTH-1:0]   r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DWIDTH-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [AWIDTH-1:0]   r_paddr;
  logic [DWIDTH-1:0]   r_pwdata;
  logic [TWIDTH-1:0]   w_cnt_inc;
  logic                w_timeout;
  // saturating wait-state count; a zero TIMEOUT never matches
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO_LIMIT);
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (REQ_VALID && r_req_ready) begin
            r_pwrite    <= REQ_WRITE;
            r_paddr     <= REQ_ADDR;
            r_pwdata    <= REQ_WDATA;
            r_psel      <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_rsp_rdata   <= '0;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_psel        <= 1'b0;
              r_penable     <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_state       <= RESP;
            end
          end
        end
        RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end
  assign REQ_READY   = r_req_ready;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_RDATA   = r_rsp_rdata;
  assign RSP_ERR     = r_rsp_err;
  assign RSP_TIMEOUT = r_rsp_timeout;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed and randomized checks of apb_cmd_master against a
// transaction-level reference model, with an APB slave model and protocol checker.
module tb_apb_cmd_master;
  localparam int TO = 16;
  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       REQ_VALID = 1'b0, REQ_WRITE = 1'b0;
  logic [7:0] REQ_ADDR = '0, REQ_WDATA = '0;
  logic       REQ_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT;
  logic       RSP_READY = 1'b0;
  logic [7:0] RSP_RDATA, PADDR, PWDATA, PRDATA;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  int total = 0, bad = 0;
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  int   waits = 0, acc_cnt = 0;
  logic slv_err = 1'b0;
  logic p_sel = 1'b0, p_en = 1'b0, p_write = 1'b0;
  logic [7:0] p_addr = '0, p_wdata = '0;

  apb_cmd_master #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(TO), .TWIDTH(8)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // slave: ready after `waits` ACCESS cycles; ready is also high outside ACCESS when waits==0
  assign PREADY  = (acc_cnt >= waits);
  assign PRDATA  = slv_mem[PADDR];
  assign PSLVERR = slv_err;
  always @(posedge PCLK) begin
    acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) slv_mem[PADDR] <= PWDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESETN) begin
      if (PENABLE) chk("apb_en_without_sel", PSEL, 1);
      if (PSEL && !p_sel) chk("apb_setup_first", PENABLE, 0);
      if (PENABLE && !p_en) chk("apb_one_setup", p_sel, 1);
      if (PENABLE) chk("apb_bus_stable", {PADDR, PWRITE, PWDATA}, {p_addr, p_write, p_wdata});
    end
    p_sel = PSEL; p_en = PENABLE; p_write = PWRITE; p_addr = PADDR; p_wdata = PWDATA;
  end

  task automatic txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input int w, input logic e, input int hold);
    int cyc, en_cyc, lat;
    logic to, exp_err;
    logic [7:0] exp_rd;
    to      = (w >= TO);
    lat     = to ? 2 + TO : 3 + w;
    exp_err = to || e;
    exp_rd  = (wr || to) ? 8'h00 : ref_mem[addr];
    waits = w; slv_err = e;
    @(negedge PCLK);
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = addr; REQ_WDATA = wdata;
    cyc = 0;
    while (!REQ_READY && cyc < 10) begin @(negedge PCLK); cyc++; end
    chk("req_ready", REQ_READY, 1);
    @(negedge PCLK);
    REQ_VALID = 1'b0; REQ_WRITE = 1'($urandom); REQ_ADDR = 8'($urandom); REQ_WDATA = 8'($urandom);
    chk("setup_phase", {PSEL, PENABLE, REQ_READY}, 3'b100);
    chk("setup_bus", {PADDR, PWRITE, PWDATA}, {addr, wr, wdata});
    cyc = 1; en_cyc = 0;
    while (!RSP_VALID && cyc < 40) begin
      @(negedge PCLK); cyc++;
      if (PENABLE) en_cyc++;
    end
    chk("latency", cyc, lat);
    chk("penable_cycles", en_cyc, lat - 2);
    chk("rsp_fields", {RSP_RDATA, RSP_ERR, RSP_TIMEOUT}, {exp_rd, exp_err, to});
    chk("rsp_bus_idle", {PSEL, PENABLE}, 0);
    if (wr && !exp_err) ref_mem[addr] = wdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      chk("rsp_hold", {RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, REQ_READY},
          {1'b1, exp_rd, exp_err, to, 1'b0});
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    chk("rsp_consumed", {RSP_VALID, REQ_READY}, 2'b01);
  endtask

  initial begin
    int cyc, r, w;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    repeat (2) @(negedge PCLK);
    chk("reset_outputs", {REQ_READY, RSP_VALID, PSEL, PENABLE, RSP_ERR, RSP_TIMEOUT}, 0);
    PRESETN = 1'b1;
    chk("release_ready_low", REQ_READY, 0);
    @(negedge PCLK);
    chk("release_ready_high", REQ_READY, 1);
    txn(1'b1, 8'h12, 8'h3C, 0, 1'b0, 0);
    chk("slave_ram_12", slv_mem[8'h12], 8'h3C);
    txn(1'b0, 8'h12, 8'h00, 0, 1'b0, 0);
    txn(1'b1, 8'h21, 8'h5A, 3, 1'b0, 0);
    txn(1'b0, 8'h21, 8'h00, TO, 1'b0, 0);
    txn(1'b0, 8'h12, 8'h00, 0, 1'b1, 0);
    txn(1'b1, 8'h30, 8'h99, 1, 1'b0, 5);
    waits = 10; slv_err = 1'b0;
    @(negedge PCLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 8'h40; REQ_WDATA = 8'h77;
    cyc = 0;
    while (!REQ_READY && cyc < 10) begin @(negedge PCLK); cyc++; end
    chk("rst_req_ready", REQ_READY, 1);
    @(negedge PCLK);
    REQ_VALID = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETN = 1'b0;
    #1 chk("rst_async_drop", {PSEL, PENABLE, RSP_VALID, REQ_READY}, 0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    chk("rst_release_low", REQ_READY, 0);
    @(negedge PCLK);
    chk("rst_release_high", {REQ_READY, RSP_VALID}, 2'b10);
    txn(1'b0, 8'h40, 8'h00, 0, 1'b0, 0);
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? int'($urandom_range(0, 3)) : (r < 8) ? int'($urandom_range(16, 19))
                                                         : int'($urandom_range(4, 15));
      txn(1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom), w,
          ($urandom_range(0, 6) == 0), int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-master APB3 controller: accepts one command at a time on a valid/ready request port and drives one APB transfer per command to a single slave select.
- Returns read data and error status on a valid/ready response port.
- Sits directly upstream of APB slaves (e.g. the slave model) and owns PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Includes a wait-state timeout so a stuck PREADY cannot hang the bus.

Parameters:
- AWIDTH, 8, APB address width.
- DWIDTH, 8, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced abort; 0 disables the timeout.
- TWIDTH, 8, timeout counter width; must satisfy TIMEOUT < 2**TWIDTH.

Ports:
- PCLK  in  1  clock, all logic on the rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  command present.
- REQ_READY  out  1  command accepted when high with REQ_VALID.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  AWIDTH  command address.
- REQ_WDATA  in  DWIDTH  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  DWIDTH  read data; 0 for writes.
- RSP_ERR  out  1  PSLVERR captured or timeout.
- RSP_TIMEOUT  out  1  abort was caused by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  DWIDTH  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (asynchronous, PRESETN low): state IDLE; all outputs 0, including REQ_READY. REQ_READY rises on the first clock after reset release.
- States:
  - IDLE: REQ_READY=1. On REQ_VALID, latch write, addr and wdata into registers and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the latched registers. Lasts exactly one cycle, then go to ACCESS with the timeout counter cleared.
  - ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA unchanged from SETUP.
    - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into the response registers, go to RESP.
    - PREADY=0: increment the counter. When TIMEOUT≠0 and the counter reaches TIMEOUT, go to RESP with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - RESP: PSEL=PENABLE=0, RSP_VALID=1, response outputs held stable. On RSP_READY go to IDLE.
- Latency: command accept to RSP_VALID is 3 cycles with zero wait states (SETUP, ACCESS, RESP), plus one cycle per wait state.
- Outside SETUP/ACCESS, PADDR/PWRITE/PWDATA hold their last values; PSEL and PENABLE are 0.
- No back-to-back transfers. PSEL drops for at least one cycle (RESP) between transfers, so PSEL is never high more than (2 + wait states) cycles.
- PENABLE is high only in ACCESS and is always preceded by exactly one SETUP cycle with the same PADDR/PWRITE/PWDATA.
- The request is not re-sampled after acceptance. REQ_* changes during a transfer have no effect.
- A timeout abort deasserts PSEL/PENABLE immediately. A late PREADY is ignored.
- PSLVERR is sampled only in the ACCESS cycle where PREADY=1.
- RSP_VALID stays high until RSP_READY. There is no new acceptance while in RESP.
- Reset mid-transfer: the bus returns to idle asynchronously and the pending command is dropped with no response.
- Counter saturates; it never wraps.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, SETUP=1, ACCESS=2, RESP=3).
- No sub-module. The timeout counter is small enough to stay inline.

Test Plan:
- Write 0x3C to addr 0x12 with PREADY tied 1:
  - PSEL rises 1 cycle after acceptance and PENABLE the cycle after.
  - RSP_VALID 3 cycles after acceptance with RSP_ERR=0.
  - Slave RAM[0x12] = 0x3C.
- Read back addr 0x12 → RSP_RDATA=0x3C, RSP_ERR=0.
- Write, then hold PREADY low for 3 ACCESS cycles:
  - PENABLE stays high 4 cycles with PADDR/PWDATA stable.
  - Response arrives on cycle 6.
- PREADY held 0 with TIMEOUT=16:
  - Abort after 16 ACCESS cycles with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - PSEL=0 in the following cycle.
- PSLVERR=1 with PREADY=1 on a read → RSP_ERR=1, RSP_TIMEOUT=0.
- Hold RSP_READY=0 for 5 cycles, then assert PRESETN low during a subsequent ACCESS:
  - Response held stable until RSP_READY.
  - On reset, PSEL/PENABLE/RSP_VALID drop immediately with no clock edge, and REQ_READY returns 1 one cycle after release.
- Throughout all scenarios, a protocol checker reports no APB violations.
